ttm4_run_ctrl: RTL and testbench

//  Run/halt/single-step sequencer and program-memory write arbiter for the TTM4 CPU.

---
 rtl/ttm4_ctrl_pkg.sv | 17 +
 rtl/ttm4_run_ctrl_if.sv | 44 ++++
 rtl/ttm4_sat_counter.sv | 19 +
 rtl/ttm4_run_ctrl.sv | 104 ++++++++++
 tb/tb_ttm4_run_ctrl.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/ttm4_ctrl_pkg.sv
// Shared types and default widths for the TTM4 run/halt/step controller.
package ttm4_ctrl_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int INSTR_W_DEF    = 15;
  localparam int CNT_W_DEF      = 16;
  localparam int RST_CYCLES_DEF = 4;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_HALT  = 3'd1,
    S_RUN   = 3'd2,
    S_STEP  = 3'd3,
    S_LOAD  = 3'd4
  } runState_t;

endpackage

// File: rtl/ttm4_run_ctrl_if.sv
// Host, CPU and program-memory signals of the run controller.
interface ttm4_run_ctrl_if
  import ttm4_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
);
  logic               HOST_RESET;
  logic               HOST_RUN;
  logic               HOST_HALT;
  logic               HOST_STEP;
  logic               HOST_WR_REQ;
  logic [ADDR_W-1:0]  HOST_WR_ADDR;
  logic [INSTR_W-1:0] HOST_WR_DATA;
  logic               HOST_WR_ACK;
  logic               BREAK_EN;
  logic [ADDR_W-1:0]  BREAK_ADDR;
  logic [ADDR_W-1:0]  CPU_PC;
  logic               CPU_CE;
  logic               CPU_RST;
  logic [ADDR_W-1:0]  MEM_ADDR;
  logic [INSTR_W-1:0] MEM_WDATA;
  logic               MEM_WE;
  logic               HALTED;
  logic [2:0]         STATE;
  logic [CNT_W-1:0]   CYCLE_CNT;

  modport master (
    output HOST_RESET, HOST_RUN, HOST_HALT, HOST_STEP,
    output HOST_WR_REQ, HOST_WR_ADDR, HOST_WR_DATA,
    output BREAK_EN, BREAK_ADDR, CPU_PC,
    input  HOST_WR_ACK, CPU_CE, CPU_RST, MEM_ADDR, MEM_WDATA, MEM_WE,
    input  HALTED, STATE, CYCLE_CNT
  );

  modport slave (
    input  HOST_RESET, HOST_RUN, HOST_HALT, HOST_STEP,
    input  HOST_WR_REQ, HOST_WR_ADDR, HOST_WR_DATA,
    input  BREAK_EN, BREAK_ADDR, CPU_PC,
    output HOST_WR_ACK, CPU_CE, CPU_RST, MEM_ADDR, MEM_WDATA, MEM_WE,
    output HALTED, STATE, CYCLE_CNT
  );
endinterface

// File: rtl/ttm4_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear, async active-high reset.
module ttm4_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end
endmodule

// File: rtl/ttm4_run_ctrl.sv
// Run/halt/single-step sequencer and program-memory write arbiter for the TTM4 CPU.
//  state   | meaning
//  S_RESET | CPU held in reset for RST_CYCLES, cycle counter cleared
//  S_HALT  | idle; accepts run, step or program write
//  S_RUN   | free-run until host halt or breakpoint
//  S_STEP  | one enabled CPU cycle
//  S_LOAD  | one program-memory write cycle with ack
module ttm4_run_ctrl
  import ttm4_ctrl_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int INSTR_W    = INSTR_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int RST_CYCLES = RST_CYCLES_DEF
) (
  input  logic           CLK,
  input  logic           RST,
  ttm4_run_ctrl_if.slave bus
);
  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_INIT = RC_W'(RST_CYCLES - 1);

  runState_t          state, nextState;
  logic [RC_W-1:0]    rstCnt;
  logic               wrBusy;
  logic               first;
  logic [ADDR_W-1:0]  wrAddr;
  logic [INSTR_W-1:0] wrData;
  logic               cpuCe;
  logic               bpHit;

  always_comb begin
    nextState = state;
    cpuCe     = 1'b0;
    bpHit     = 1'b0;
    case (state)
      S_RESET: if (rstCnt == '0) nextState = S_HALT;
      S_HALT: begin
        if (bus.HOST_WR_REQ && !wrBusy) nextState = S_LOAD;
        else if (bus.HOST_RUN)          nextState = S_RUN;
        else if (bus.HOST_STEP)         nextState = S_STEP;
      end
      S_RUN: begin
        // first masks the breakpoint so a resume executes the instruction it stopped on
        bpHit = bus.BREAK_EN && (bus.CPU_PC == bus.BREAK_ADDR) && !first;
        cpuCe = !bpHit;
        if (bus.HOST_HALT || bpHit) nextState = S_HALT;
      end
      S_STEP: begin
        cpuCe     = 1'b1;
        nextState = S_HALT;
      end
      S_LOAD:  nextState = S_HALT;
      default: nextState = S_RESET;
    endcase
    if (bus.HOST_RESET) nextState = S_RESET;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_RESET;
      rstCnt <= RC_INIT;
      wrBusy <= 1'b0;
      first  <= 1'b0;
      wrAddr <= '0;
      wrData <= '0;
    end else begin
      state <= nextState;
      if (state != S_RESET || bus.HOST_RESET)
        rstCnt <= RC_INIT;
      else if (rstCnt != '0)
        rstCnt <= rstCnt - 1'b1;
      if (state == S_LOAD)
        wrBusy <= 1'b1;
      else if (!bus.HOST_WR_REQ)
        wrBusy <= 1'b0;
      if (state == S_HALT && nextState == S_RUN)
        first <= 1'b1;
      else if (state == S_RUN)
        first <= 1'b0;
      if (state == S_HALT && nextState == S_LOAD) begin
        wrAddr <= bus.HOST_WR_ADDR;
        wrData <= bus.HOST_WR_DATA;
      end
    end
  end

  assign bus.CPU_CE      = cpuCe;
  assign bus.CPU_RST     = (state == S_RESET);
  assign bus.HALTED      = (state == S_HALT);
  assign bus.MEM_WE      = (state == S_LOAD);
  assign bus.HOST_WR_ACK = (state == S_LOAD);
  assign bus.MEM_ADDR    = (state == S_LOAD) ? wrAddr : bus.CPU_PC;
  assign bus.MEM_WDATA   = wrData;
  assign bus.STATE       = state;

  ttm4_sat_counter #(.CNT_W(CNT_W)) cycleCounter (
    .clk   (CLK),
    .rst   (RST),
    .clear (state == S_RESET),
    .inc   (cpuCe),
    .count (bus.CYCLE_CNT)
  );
endmodule

// File: tb/tb_ttm4_run_ctrl.sv
// Directed bench for ttm4_run_ctrl: reset, loader writes, stepping, breakpoints, saturation.
module tb_ttm4_run_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nCmp = 0;
  int   nBad = 0;

  always #5 clk = ~clk;

  ttm4_run_ctrl_if #(.CNT_W(16)) bus ();
  ttm4_run_ctrl_if #(.CNT_W(4))  bus2 ();

  ttm4_run_ctrl #(.CNT_W(16)) dut  (.CLK(clk), .RST(rst), .bus(bus.slave));
  ttm4_run_ctrl #(.CNT_W(4))  dut2 (.CLK(clk), .RST(rst), .bus(bus2.slave));

  // Minimal CPU stand-in: PC clears in reset and advances on each enabled cycle
  always @(posedge clk) begin
    if (bus.CPU_RST)     bus.CPU_PC <= 8'h00;
    else if (bus.CPU_CE) bus.CPU_PC <= bus.CPU_PC + 8'h01;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic       sawBp;
    logic       ceAtBp;
    int         n;
    bus.HOST_RESET = 0; bus.HOST_RUN = 0; bus.HOST_HALT = 0; bus.HOST_STEP = 0;
    bus.HOST_WR_REQ = 0; bus.HOST_WR_ADDR = '0; bus.HOST_WR_DATA = '0;
    bus.BREAK_EN = 0; bus.BREAK_ADDR = '0;
    bus2.HOST_RESET = 0; bus2.HOST_RUN = 0; bus2.HOST_HALT = 0; bus2.HOST_STEP = 0;
    bus2.HOST_WR_REQ = 0; bus2.HOST_WR_ADDR = '0; bus2.HOST_WR_DATA = '0;
    bus2.BREAK_EN = 0; bus2.BREAK_ADDR = '0; bus2.CPU_PC = '0;

    tick();
    chk("rst_cpu_rst", bus.CPU_RST, 1);
    chk("rst_state", bus.STATE, 0);
    chk("rst_ce", bus.CPU_CE, 0);
    chk("rst_we", bus.MEM_WE, 0);
    chk("rst_ack", bus.HOST_WR_ACK, 0);
    chk("rst_halted", bus.HALTED, 0);
    chk("rst_cnt", bus.CYCLE_CNT, 0);
    chk("rst_wdata", bus.MEM_WDATA, 0);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_hold", bus.CPU_RST, 1);
    end
    tick();
    chk("post_rst_halted", bus.HALTED, 1);
    chk("post_rst_state", bus.STATE, 1);
    chk("post_rst_cpu_rst", bus.CPU_RST, 0);
    chk("post_rst_cnt", bus.CYCLE_CNT, 0);

    // second instance free-runs from here to reach saturation
    bus2.HOST_RUN = 1;

    bus.HOST_WR_REQ = 1; bus.HOST_WR_ADDR = 8'h05; bus.HOST_WR_DATA = 15'h1234;
    tick();
    bus2.HOST_RUN = 0;
    chk("wr_we", bus.MEM_WE, 1);
    chk("wr_addr", bus.MEM_ADDR, 8'h05);
    chk("wr_data", bus.MEM_WDATA, 15'h1234);
    chk("wr_ack", bus.HOST_WR_ACK, 1);
    chk("wr_state", bus.STATE, 4);
    tick();
    chk("wr_ack_drop", bus.HOST_WR_ACK, 0);
    chk("wr_addr_pc", bus.MEM_ADDR, 8'h00);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("wr_held_we", bus.MEM_WE, 0);
      chk("wr_held_state", bus.STATE, 1);
    end
    bus.HOST_WR_REQ = 0;
    tick();

    for (int k = 0; k < 3; k++) begin
      bus.HOST_STEP = 1;
      tick();
      bus.HOST_STEP = 0;
      chk("step_ce", bus.CPU_CE, 1);
      tick();
      chk("step_halted", bus.HALTED, 1);
      chk("step_cnt", bus.CYCLE_CNT, k + 1);
    end
    chk("step_pc", bus.CPU_PC, 8'h03);

    bus.BREAK_EN = 1; bus.BREAK_ADDR = 8'h10;
    bus.HOST_RUN = 1;
    tick();
    bus.HOST_RUN = 0;
    chk("run_state", bus.STATE, 2);
    sawBp = 0; ceAtBp = 1'bx; n = 0;
    while (bus.STATE == 3'd2 && n < 60) begin
      if (bus.CPU_PC == 8'h10) begin
        sawBp  = 1;
        ceAtBp = bus.CPU_CE;
      end
      tick();
      n++;
    end
    chk("bp_seen", sawBp, 1);
    chk("bp_ce", ceAtBp, 0);
    chk("bp_state", bus.STATE, 1);
    chk("bp_pc", bus.CPU_PC, 8'h10);
    chk("bp_cnt", bus.CYCLE_CNT, 16);

    bus.HOST_RUN = 1;
    tick();
    bus.HOST_RUN = 0;
    chk("resume_state", bus.STATE, 2);
    chk("resume_ce", bus.CPU_CE, 1);
    tick();
    chk("resume_pc", bus.CPU_PC, 8'h11);
    bus.HOST_HALT = 1;
    tick();
    bus.HOST_HALT = 0;
    chk("halt_state", bus.HALTED, 1);
    chk("halt_pc", bus.CPU_PC, 8'h12);
    chk("halt_cnt", bus.CYCLE_CNT, 18);

    chk("sat_cnt4", bus2.CYCLE_CNT, 4'hF);

    bus.HOST_WR_REQ = 1; bus.HOST_WR_ADDR = 8'h22; bus.HOST_WR_DATA = 15'h3ABC;
    tick();
    chk("load2_we", bus.MEM_WE, 1);
    chk("load2_addr", bus.MEM_ADDR, 8'h22);
    #1 rst = 1;
    #1;
    chk("arst_we", bus.MEM_WE, 0);
    chk("arst_ack", bus.HOST_WR_ACK, 0);
    chk("arst_state", bus.STATE, 0);
    chk("arst_cpu_rst", bus.CPU_RST, 1);
    chk("arst_wdata", bus.MEM_WDATA, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
